// File: rtl/retire_trace_tx_if.sv
// Trace stream carrying one retired-instruction record per accepted beat
// from the transmitter (master) to the external checker (slave).
interface retire_trace_tx_if #(
   parameter int SEQ_W = 16
);
   logic             tr_valid;
   logic             tr_ready;
   logic [SEQ_W-1:0] tr_seq;
   logic [31:0]      tr_pc;
   logic [31:0]      tr_instr;
   logic             tr_wr_en;
   logic [4:0]       tr_wr_reg;
   logic [31:0]      tr_wr_data;

   modport master (
      output tr_valid, tr_seq, tr_pc, tr_instr, tr_wr_en, tr_wr_reg, tr_wr_data,
      input  tr_ready
   );

   modport slave (
      input  tr_valid, tr_seq, tr_pc, tr_instr, tr_wr_en, tr_wr_reg, tr_wr_data,
      output tr_ready
   );
endinterface

// File: rtl/retire_trace_tx.sv
// Retirement-trace transmitter: buffers one record per retired instruction,
// streams them to a checker, and drains/stops the CPU on the exit syscall.
module retire_trace_tx #(
   parameter int DEPTH = 8,
   parameter int SEQ_W = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     ret_valid,
   input  logic [31:0]              ret_pc,
   input  logic [31:0]              ret_instr,
   input  logic                     ret_wr_en,
   input  logic [4:0]               ret_wr_reg,
   input  logic [31:0]              ret_wr_data,
   input  logic [31:0]              ret_v0,
   output logic                     cpu_stall,
   retire_trace_tx_if.master        tr,
   output logic [$clog2(DEPTH):0]   occupancy,
   output logic                     test_done,
   output logic                     drop_err
);
   localparam int AW = $clog2(DEPTH);

   localparam logic [1:0] ST_RUN   = 2'd0;
   localparam logic [1:0] ST_DRAIN = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   typedef struct packed {
      logic [SEQ_W-1:0] seq;
      logic [31:0]      pc;
      logic [31:0]      instr;
      logic             wr_en;
      logic [4:0]       wr_reg;
      logic [31:0]      wr_data;
   } rec_t;

   rec_t          mem [DEPTH];
   rec_t          rec_in;
   rec_t          head;
   logic [AW-1:0] wr_ptr_reg;
   logic [AW-1:0] rd_ptr_reg;
   logic [AW:0]   occ_reg;
   logic [AW:0]   occ_next;
   logic [SEQ_W-1:0] seq_reg;
   logic [1:0]    state_reg;
   logic [1:0]    state_next;
   logic          test_done_reg;
   logic          drop_err_reg;
   logic          full;
   logic          in_run;
   logic          push;
   logic          pop;
   logic          end_hit;

   assign full    = (occ_reg == (AW+1)'(DEPTH));
   assign in_run  = (state_reg == ST_RUN);
   assign push    = ret_valid && in_run && !full;
   assign pop     = tr.tr_valid && tr.tr_ready;
   assign end_hit = push && (ret_instr == 32'h0000_000C) && (ret_v0 == 32'h0000_000A);

   // Full is taken from registered occupancy, so a pop never frees a slot
   // for a push in the same cycle; the CPU was already told to stall.
   assign occ_next = occ_reg + (AW+1)'(push) - (AW+1)'(pop);

   assign rec_in = '{seq: seq_reg, pc: ret_pc, instr: ret_instr, wr_en: ret_wr_en,
                     wr_reg: ret_wr_reg, wr_data: ret_wr_data};

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_RUN:   if (end_hit) state_next = ST_DRAIN;
         ST_DRAIN: if (occ_next == '0) state_next = ST_DONE;
         ST_DONE:  state_next = ST_DONE;
         default:  state_next = ST_RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         occ_reg       <= '0;
         seq_reg       <= '0;
         state_reg     <= ST_RUN;
         test_done_reg <= 1'b0;
         drop_err_reg  <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
            seq_reg    <= seq_reg + SEQ_W'(1);
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
         end
         if (ret_valid && in_run && full) begin
            drop_err_reg <= 1'b1;
         end
         occ_reg       <= occ_next;
         state_reg     <= state_next;
         test_done_reg <= (state_next == ST_DONE);
      end
   end

   // Record storage has no reset; stale entries are never presented.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_reg] <= rec_in;
      end
   end

   assign tr.tr_valid = (occ_reg != '0);
   assign head        = tr.tr_valid ? mem[rd_ptr_reg] : '0;

   assign tr.tr_seq     = head.seq;
   assign tr.tr_pc      = head.pc;
   assign tr.tr_instr   = head.instr;
   assign tr.tr_wr_en   = head.wr_en;
   assign tr.tr_wr_reg  = head.wr_reg;
   assign tr.tr_wr_data = head.wr_data;

   assign cpu_stall = !in_run || full;
   assign occupancy = occ_reg;
   assign test_done = test_done_reg;
   assign drop_err  = drop_err_reg;
endmodule
